dense_seq_ctrl: RTL and testbench

Sequencing controller for a fully-connected layer that time-multiplexes one multiply-accumulate unit over all neurons instead of computing every dot product in a single cycle. It sits between the pooled-feature buffer and the next layer. It walks the input buffer and the weight/bias ROMs one element per cycle, accumulates, adds bias, clamps, and streams one result per neuron over a valid/ready handshake.

---
 rtl/dense_seq_ctrl_pkg.sv | 33 +++
 rtl/dense_seq_ctrl_if.sv | 41 ++++
 rtl/dense_seq_ctrl_mac.sv | 45 ++++
 rtl/dense_seq_ctrl.sv | 135 +++++++++++++
 tb/tb_dense_seq_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dense_seq_ctrl_pkg.sv
// Shared types and helpers for the dense-layer sequencer (FSM states, clamp, widths).
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package dense_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

  localparam int ACC_WIDTH_DEF = 32;

  // Address width for a memory of 'depth' entries; never below one bit.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Saturate a sign-extended accumulator value (ACC_WIDTH up to 64) into
  // the signed range of a data_w-bit word. Caller truncates to data_w bits.
  function automatic logic signed [63:0] clamp_sat(input logic signed [63:0] v,
                                                   input int data_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
  endfunction

endpackage

// File: rtl/dense_seq_ctrl_if.sv
// Bundle of start handshake, buffer/ROM read ports and result stream of the sequencer.
// Latency: n/a (wiring only); memories are expected to answer one cycle after the address.
// Backpressure: out_valid/out_ready on results, start_valid/start_ready on pass requests.
interface dense_seq_ctrl_if
  import dense_pkg::*;
#(
  parameter int INPUT_LEN  = 169,
  parameter int OUTPUT_LEN = 16,
  parameter int DATA_WIDTH = 8
);
  localparam int IW = addr_w(INPUT_LEN);
  localparam int WW = addr_w(INPUT_LEN * OUTPUT_LEN);
  localparam int NW = addr_w(OUTPUT_LEN);

  logic                         start_valid;
  logic                         start_ready;
  logic [IW-1:0]                in_addr;
  logic signed [DATA_WIDTH-1:0] in_data;
  logic [WW-1:0]                w_addr;
  logic signed [DATA_WIDTH-1:0] w_data;
  logic [NW-1:0]                b_addr;
  logic signed [DATA_WIDTH-1:0] b_data;
  logic                         out_valid;
  logic                         out_ready;
  logic [NW-1:0]                out_idx;
  logic signed [DATA_WIDTH-1:0] out_data;
  logic                         busy;
  logic                         done;

  // Sequencer side.
  modport master (
    input  start_valid, in_data, w_data, b_data, out_ready,
    output start_ready, in_addr, w_addr, b_addr, out_valid, out_idx, out_data, busy, done
  );

  // Environment side: memories, requester and result consumer.
  modport slave (
    output start_valid, in_data, w_data, b_data, out_ready,
    input  start_ready, in_addr, w_addr, b_addr, out_valid, out_idx, out_data, busy, done
  );
endinterface

// File: rtl/dense_seq_ctrl_mac.sv
// Accumulator for one neuron: signed MAC, bias add, clamp, optional ReLU (DENSE_RELU_EN).
// Latency: acc updates on the edge after acc_en/bias_en; result is combinational from acc and inputs.
// Backpressure: none; the controller gates updates through clear/acc_en/bias_en.
module dense_mac
  import dense_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         acc_en,
  input  logic                         bias_en,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic signed [DATA_WIDTH-1:0] w_data,
  input  logic signed [DATA_WIDTH-1:0] b_data,
  output logic signed [DATA_WIDTH-1:0] result
);
  logic signed [ACC_WIDTH-1:0]    acc;
  logic signed [ACC_WIDTH-1:0]    acc_nxt;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [DATA_WIDTH-1:0]   sat;

  // Full-width product and bias, sign-extended; no saturation until the final clamp.
  always_comb begin
    prod    = in_data * w_data;
    acc_nxt = acc;
    if (acc_en)  acc_nxt = acc_nxt + ACC_WIDTH'(prod);
    if (bias_en) acc_nxt = acc_nxt + ACC_WIDTH'(b_data);
    sat = DATA_WIDTH'(clamp_sat(64'(acc_nxt), DATA_WIDTH));
`ifdef DENSE_RELU_EN
    result = sat[DATA_WIDTH-1] ? '0 : sat;
`else
    result = sat;
`endif
  end

  // Accumulator register: cleared between neurons, updated only when enabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  acc <= '0;
    else if (clear)            acc <= '0;
    else if (acc_en | bias_en) acc <= acc_nxt;
  end
endmodule

// File: rtl/dense_seq_ctrl.sv
// Fully-connected layer sequencer: one MAC walks buffer/ROMs, streams one clamped result per neuron.
// Latency: INPUT_LEN+2 cycles per neuron with out_ready high; optional ReLU via DENSE_RELU_EN.
// Backpressure: out_ready low holds OUT with data, index and addresses frozen; start only taken in IDLE.
module dense_seq_ctrl
  import dense_pkg::*;
#(
  parameter int INPUT_LEN  = 169,
  parameter int OUTPUT_LEN = 16,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  dense_seq_ctrl_if.master bus
);
  localparam int IW = addr_w(INPUT_LEN);
  localparam int WW = addr_w(INPUT_LEN * OUTPUT_LEN);
  localparam int NW = addr_w(OUTPUT_LEN);

  state_t                       state;
  logic [IW-1:0]                j;
  logic [WW-1:0]                w_addr;
  logic [NW-1:0]                n;
  logic                         start_ready;
  logic                         busy;
  logic                         done;
  logic                         out_valid;
  logic [NW-1:0]                out_idx;
  logic signed [DATA_WIDTH-1:0] out_data;
  logic signed [DATA_WIDTH-1:0] mac_result;
  logic                         mac_clear;
  logic                         mac_acc_en;
  logic                         mac_bias_en;

  // j doubles as the input address and n as the bias address; both hold outside MAC.
  assign bus.in_addr     = j;
  assign bus.w_addr      = w_addr;
  assign bus.b_addr      = n;
  assign bus.start_ready = start_ready;
  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.out_valid   = out_valid;
  assign bus.out_idx     = out_idx;
  assign bus.out_data    = out_data;

  // Datapath controls: data for address j arrives one cycle later, so the first MAC cycle adds nothing.
  always_comb begin
    mac_clear   = (state == IDLE) || (state == OUT);
    mac_acc_en  = ((state == MAC) && (j != '0)) || (state == DRAIN);
    mac_bias_en = (state == DRAIN);
  end

  dense_mac #(
    .DATA_WIDTH(DATA_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mac (
    .clk    (clk),
    .rst    (rst),
    .clear  (mac_clear),
    .acc_en (mac_acc_en),
    .bias_en(mac_bias_en),
    .in_data(bus.in_data),
    .w_data (bus.w_data),
    .b_data (bus.b_data),
    .result (mac_result)
  );

  // Sequencing FSM with registered handshake, status and address outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      j           <= '0;
      w_addr      <= '0;
      n           <= '0;
      start_ready <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      out_valid   <= 1'b0;
      out_idx     <= '0;
      out_data    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_valid_accept()) begin
            state       <= MAC;
            j           <= '0;
            w_addr      <= '0;
            n           <= '0;
            start_ready <= 1'b0;
            busy        <= 1'b1;
          end else begin
            start_ready <= 1'b1;
          end
        end
        MAC: begin
          if (j == IW'(INPUT_LEN - 1)) begin
            state <= DRAIN;
          end else begin
            j      <= j + 1'b1;
            w_addr <= w_addr + 1'b1;
          end
        end
        DRAIN: begin
          out_data  <= mac_result;
          out_idx   <= n;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (bus.out_ready) begin
            out_valid <= 1'b0;
            if (n == NW'(OUTPUT_LEN - 1)) begin
              state       <= IDLE;
              done        <= 1'b1;
              busy        <= 1'b0;
              start_ready <= 1'b1;
            end else begin
              // w_addr sits on the last weight of neuron n, so +1 is the first weight of n+1.
              n      <= n + 1'b1;
              j      <= '0;
              w_addr <= w_addr + 1'b1;
              state  <= MAC;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  function automatic logic start_valid_accept();
    return bus.start_valid && start_ready;
  endfunction
endmodule

// File: tb/tb_dense_seq_ctrl.sv
// Self-checking bench for dense_seq_ctrl, small build (4 inputs, 2 neurons), DENSE_RELU_EN aware.
// Latency: cycles are counted from the start handshake edge; cycle k is the k-th cycle after it.
// Backpressure: bench drives out_ready per scenario and models the synchronous-read memories.
module tb_dense_seq_ctrl;
  localparam int IL = 4;
  localparam int OL = 2;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dense_seq_ctrl_if #(.INPUT_LEN(IL), .OUTPUT_LEN(OL), .DATA_WIDTH(DW)) bus ();

  dense_seq_ctrl #(.INPUT_LEN(IL), .OUTPUT_LEN(OL), .DATA_WIDTH(DW), .ACC_WIDTH(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic signed [DW-1:0] in_mem [IL];
  logic signed [DW-1:0] w_mem  [IL*OL];
  logic signed [DW-1:0] b_mem  [OL];

  // Synchronous-read memories: data valid one cycle after the address.
  always @(posedge clk) begin
    bus.in_data <= in_mem[bus.in_addr];
    bus.w_data  <= w_mem[bus.w_addr];
    bus.b_data  <= b_mem[bus.b_addr];
  end

  int tests_run = 0;
  int tests_failed = 0;

  // Observations from the most recent pass.
  int obs_n, obs_first, obs_ndone, obs_unstable, obs_timeout, obs_sr_busy, obs_busy_after;
  int obs_idx [8];
  int obs_dat [8];
  int obs_done [2];

  // Reference: plain dot product plus bias, saturated to the signed 8-bit range.
  function automatic int model_out(input int nn);
    int s;
    s = 0;
    for (int k = 0; k < IL; k++) s += int'(in_mem[k]) * int'(w_mem[nn*IL + k]);
    s += int'(b_mem[nn]);
    if (s > 127) s = 127;
    if (s < -128) s = -128;
`ifdef DENSE_RELU_EN
    if (s < 0) s = 0;
`endif
    return s;
  endfunction

  task automatic load_random(input int span);
    for (int k = 0; k < IL; k++) in_mem[k] = DW'($urandom_range(0, 2*span)) - DW'(span);
    for (int k = 0; k < IL*OL; k++) w_mem[k] = DW'($urandom_range(0, 2*span)) - DW'(span);
    for (int k = 0; k < OL; k++) b_mem[k] = DW'($urandom_range(0, 2*span)) - DW'(span);
  endtask

  task automatic load_const(input int iv, input int wv, input int bv);
    for (int k = 0; k < IL; k++) in_mem[k] = DW'(iv);
    for (int k = 0; k < IL*OL; k++) w_mem[k] = DW'(wv);
    for (int k = 0; k < OL; k++) b_mem[k] = DW'(bv);
  endtask

  // Runs one pass starting at a negedge with the DUT idle; records what it sees.
  // stall: out_ready low for that many OUT cycles on the first result.
  // poke: start_valid pulses while busy. hold: start_valid kept high into a second pass.
  // abort_cyc: stop driving at that cycle (0 = never).
  task automatic run_pass(input int stall, input bit poke, input bit hold, input int abort_cyc);
    int cyc, stall_left, want_done;
    int h_dat, h_idx, h_in, h_w, h_b;
    obs_n = 0; obs_first = -1; obs_ndone = 0; obs_unstable = 0;
    obs_timeout = 0; obs_sr_busy = 0; obs_busy_after = -1;
    h_dat = 0; h_idx = 0; h_in = 0; h_w = 0; h_b = 0;
    want_done = hold ? 2 : 1;
    stall_left = stall;
    bus.start_valid = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cyc = 1;
    if (!hold) bus.start_valid = 1'b0;
    while (1) begin
      if (cyc == abort_cyc) break;
      if (cyc > 200) begin obs_timeout = 1; break; end
      if (bus.busy && bus.start_ready) obs_sr_busy++;
      if (poke) bus.start_valid = (cyc == 3 || cyc == 8);
      if (hold && obs_ndone == 1 && cyc == obs_done[0] + 1) begin
        obs_busy_after = int'(bus.busy);
        bus.start_valid = 1'b0;
      end
      if (bus.done) begin
        obs_done[obs_ndone] = cyc;
        obs_ndone++;
        if (obs_ndone == want_done) break;
      end
      if (bus.out_valid) begin
        if (obs_first < 0) obs_first = cyc;
        if (stall_left > 0) begin
          if (stall_left == stall) begin
            h_dat = int'(bus.out_data); h_idx = int'(bus.out_idx);
            h_in = int'(bus.in_addr); h_w = int'(bus.w_addr); h_b = int'(bus.b_addr);
          end else if (h_dat != int'(bus.out_data) || h_idx != int'(bus.out_idx) ||
                       h_in != int'(bus.in_addr) || h_w != int'(bus.w_addr) ||
                       h_b != int'(bus.b_addr)) begin
            obs_unstable++;
          end
          bus.out_ready = 1'b0;
          stall_left--;
        end else begin
          bus.out_ready = 1'b1;
          if (obs_n < 8) begin
            obs_idx[obs_n] = int'(bus.out_idx);
            obs_dat[obs_n] = int'(bus.out_data);
            obs_n++;
          end
        end
      end else begin
        bus.out_ready = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    bus.start_valid = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({bus.in_addr, bus.w_addr, bus.b_addr, bus.out_valid, bus.out_idx, bus.out_data,
         bus.busy, bus.done, bus.start_ready} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got in=%h w=%h b=%h ov=%b idx=%h dat=%h busy=%b done=%b sr=%b, want all 0",
               bus.in_addr, bus.w_addr, bus.b_addr, bus.out_valid, bus.out_idx, bus.out_data,
               bus.busy, bus.done, bus.start_ready);
    end
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus.start_ready !== 1'b1 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release: start_ready=%b busy=%b, want 1 0", bus.start_ready, bus.busy);
    end
  endtask

  task automatic test_basic();
    in_mem = '{8'sd1, 8'sd2, 8'sd3, 8'sd4};
    w_mem  = '{8'sd1, 8'sd1, 8'sd1, 8'sd1, -8'sd1, 8'sd0, 8'sd0, 8'sd2};
    b_mem  = '{8'sd5, -8'sd3};
    run_pass(0, 1'b0, 1'b0, 0);
    tests_run++;
    if (obs_timeout != 0 || obs_n != 2) begin
      tests_failed++;
      $display("FAIL basic_count: timeout=%0d results=%0d, want 0 2", obs_timeout, obs_n);
    end
    // n0: 1+2+3+4+5 = 15; n1: -1*1 + 2*4 - 3 = 4.
    tests_run++;
    if (obs_idx[0] != 0 || obs_dat[0] != 15) begin
      tests_failed++;
      $display("FAIL basic_n0: got (%0d,%0d) want (0,15)", obs_idx[0], obs_dat[0]);
    end
    tests_run++;
    if (obs_idx[1] != 1 || obs_dat[1] != 4) begin
      tests_failed++;
      $display("FAIL basic_n1: got (%0d,%0d) want (1,4)", obs_idx[1], obs_dat[1]);
    end
    tests_run++;
    if (obs_first != IL + 2) begin
      tests_failed++;
      $display("FAIL basic_first_valid: cycle %0d want %0d", obs_first, IL + 2);
    end
    // Final handshake ends cycle OL*(IL+2); done is high in the following cycle.
    tests_run++;
    if (obs_done[0] != OL*(IL+2) + 1) begin
      tests_failed++;
      $display("FAIL basic_done_cycle: cycle %0d want %0d", obs_done[0], OL*(IL+2) + 1);
    end
    tests_run++;
    if (bus.start_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_ready_with_done: start_ready=%b want 1", bus.start_ready);
    end
    @(negedge clk);
    tests_run++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_done_pulse: done=%b busy=%b want 0 0", bus.done, bus.busy);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      load_random((it % 2 == 0) ? 12 : 127);
      run_pass(0, 1'b0, 1'b0, 0);
      for (int k = 0; k < OL; k++) begin
        tests_run++;
        if (obs_n != OL || obs_idx[k] != k || obs_dat[k] != model_out(k)) begin
          tests_failed++;
          $display("FAIL random_%0d_n%0d: got (%0d,%0d) n=%0d want (%0d,%0d)",
                   it, k, obs_idx[k], obs_dat[k], obs_n, k, model_out(k));
        end
      end
    end
  endtask

  task automatic test_saturation();
    for (int c = 0; c < 2; c++) begin
      load_const(127, (c == 0) ? 127 : -128, 0);
      run_pass(0, 1'b0, 1'b0, 0);
      tests_run++;
      if (obs_n != OL || obs_dat[0] != model_out(0) || obs_dat[1] != model_out(1)) begin
        tests_failed++;
        $display("FAIL saturation_%0d: got %0d,%0d want %0d,%0d",
                 c, obs_dat[0], obs_dat[1], model_out(0), model_out(1));
      end
    end
  endtask

  task automatic test_backpressure();
    load_random(12);
    run_pass(10, 1'b0, 1'b0, 0);
    tests_run++;
    if (obs_unstable != 0) begin
      tests_failed++;
      $display("FAIL stall_stable: %0d changed samples, want 0", obs_unstable);
    end
    tests_run++;
    if (obs_done[0] != OL*(IL+2) + 1 + 10) begin
      tests_failed++;
      $display("FAIL stall_length: done cycle %0d want %0d", obs_done[0], OL*(IL+2) + 11);
    end
    tests_run++;
    if (obs_n != OL || obs_dat[0] != model_out(0) || obs_dat[1] != model_out(1)) begin
      tests_failed++;
      $display("FAIL stall_data: got %0d,%0d want %0d,%0d",
               obs_dat[0], obs_dat[1], model_out(0), model_out(1));
    end
  endtask

  task automatic test_ignore_start();
    load_random(12);
    run_pass(0, 1'b1, 1'b0, 0);
    tests_run++;
    if (obs_sr_busy != 0 || obs_done[0] != OL*(IL+2) + 1) begin
      tests_failed++;
      $display("FAIL ignore_start: ready-while-busy=%0d done cycle %0d, want 0 %0d",
               obs_sr_busy, obs_done[0], OL*(IL+2) + 1);
    end
    tests_run++;
    if (obs_n != OL || obs_dat[0] != model_out(0) || obs_dat[1] != model_out(1)) begin
      tests_failed++;
      $display("FAIL ignore_start_data: got %0d,%0d want %0d,%0d",
               obs_dat[0], obs_dat[1], model_out(0), model_out(1));
    end
  endtask

  task automatic test_back_to_back();
    load_random(12);
    run_pass(0, 1'b0, 1'b1, 0);
    tests_run++;
    if (obs_ndone != 2 || obs_done[1] != 2*OL*(IL+2) + 2 || obs_busy_after != 1) begin
      tests_failed++;
      $display("FAIL b2b_timing: dones=%0d second=%0d busy_after=%0d, want 2 %0d 1",
               obs_ndone, obs_done[1], obs_busy_after, 2*OL*(IL+2) + 2);
    end
    for (int k = 0; k < 2*OL; k++) begin
      tests_run++;
      if (obs_n != 2*OL || obs_idx[k] != k % OL || obs_dat[k] != model_out(k % OL)) begin
        tests_failed++;
        $display("FAIL b2b_result_%0d: got (%0d,%0d) n=%0d want (%0d,%0d)",
                 k, obs_idx[k], obs_dat[k], obs_n, k % OL, model_out(k % OL));
      end
    end
  endtask

  task automatic test_reset_mid();
    load_random(12);
    // Cycle 8 is the second MAC cycle of neuron 1.
    run_pass(0, 1'b0, 1'b0, 8);
    rst = 1'b0;
    #1;
    tests_run++;
    if ({bus.in_addr, bus.w_addr, bus.b_addr, bus.out_valid, bus.out_idx, bus.out_data,
         bus.busy, bus.done, bus.start_ready} !== '0) begin
      tests_failed++;
      $display("FAIL midreset_outputs: in=%h w=%h b=%h ov=%b idx=%h dat=%h busy=%b done=%b sr=%b, want all 0",
               bus.in_addr, bus.w_addr, bus.b_addr, bus.out_valid, bus.out_idx, bus.out_data,
               bus.busy, bus.done, bus.start_ready);
    end
    repeat (2) @(negedge clk);
    tests_run++;
    if (bus.done !== 1'b0 || bus.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_quiet: done=%b out_valid=%b want 0 0", bus.done, bus.out_valid);
    end
    rst = 1'b1;
    @(negedge clk);
    load_random(12);
    run_pass(0, 1'b0, 1'b0, 0);
    tests_run++;
    if (obs_n != OL || obs_idx[0] != 0 || obs_dat[0] != model_out(0)) begin
      tests_failed++;
      $display("FAIL midreset_restart: got (%0d,%0d) n=%0d want (0,%0d)",
               obs_idx[0], obs_dat[0], obs_n, model_out(0));
    end
  endtask

  initial begin
    bus.start_valid = 1'b0;
    bus.out_ready = 1'b0;
    load_const(0, 0, 0);
    #2;
    test_reset();
    test_basic();
    test_random();
    test_saturation();
    test_backpressure();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1);
  end
endmodule
